// File: rtl/moesi_pkg.sv
// Shared MOESI line-state codes, responder FSM encoding and the probe transition table.
package moesi_pkg;

  localparam int unsigned MOESI_WID = 3;

  localparam logic [MOESI_WID-1:0] INVALID   = 3'b000;
  localparam logic [MOESI_WID-1:0] SHARED    = 3'b001;
  localparam logic [MOESI_WID-1:0] EXCLUSIVE = 3'b010;
  localparam logic [MOESI_WID-1:0] MODIFIED  = 3'b011;
  localparam logic [MOESI_WID-1:0] OWNED     = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } fsm_e;

  typedef struct packed {
    logic [MOESI_WID-1:0] state;
    logic                 supply;
    logic                 dirty;
  } probe_res_t;

  // Codes 101..111 are not legal states and behave as INVALID.
  function automatic logic is_valid_state(input logic [MOESI_WID-1:0] state);
    return (state == SHARED) || (state == EXCLUSIVE) ||
           (state == MODIFIED) || (state == OWNED);
  endfunction

  function automatic probe_res_t probe_next_state(input logic [MOESI_WID-1:0] state,
                                                  input logic                 is_write);
    probe_res_t res;
    res = '{state: INVALID, supply: 1'b0, dirty: 1'b0};
    if (is_write) begin
      res.supply = (state == MODIFIED) || (state == OWNED);
      res.dirty  = res.supply;
    end else begin
      case (state)
        MODIFIED:  res = '{state: OWNED,  supply: 1'b1, dirty: 1'b1};
        OWNED:     res = '{state: OWNED,  supply: 1'b1, dirty: 1'b1};
        EXCLUSIVE: res = '{state: SHARED, supply: 1'b1, dirty: 1'b0};
        SHARED:    res = '{state: SHARED, supply: 1'b0, dirty: 1'b0};
        default:   res = '{state: INVALID, supply: 1'b0, dirty: 1'b0};
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/moesi_line_array.sv
// Direct-mapped tag/state storage: combinational read, fill write plus snoop state update.
module moesi_line_array
  import moesi_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned IDX_WID   = 4,
  parameter int unsigned TAG_WID   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fill_en_i,
  input  logic [IDX_WID-1:0]   fill_idx_i,
  input  logic [TAG_WID-1:0]   fill_tag_i,
  input  logic [MOESI_WID-1:0] fill_state_i,
  input  logic                 upd_en_i,
  input  logic [IDX_WID-1:0]   upd_idx_i,
  input  logic [MOESI_WID-1:0] upd_state_i,
  input  logic [IDX_WID-1:0]   rd_idx_i,
  output logic [TAG_WID-1:0]   rd_tag_o,
  output logic [MOESI_WID-1:0] rd_state_o
);

  logic [TAG_WID-1:0]   tag_q   [NUM_LINES];
  logic [MOESI_WID-1:0] state_q [NUM_LINES];

  // The fill owns the line when both writers target the same index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        tag_q[i]   <= '0;
        state_q[i] <= INVALID;
      end
    end else begin
      if (upd_en_i && !(fill_en_i && (fill_idx_i == upd_idx_i))) begin
        state_q[upd_idx_i] <= upd_state_i;
      end
      if (fill_en_i) begin
        tag_q[fill_idx_i]   <= fill_tag_i;
        state_q[fill_idx_i] <= fill_state_i;
      end
    end
  end

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_state_o = state_q[rd_idx_i];

endmodule

// File: rtl/moesi_snoop_responder.sv
// Bus snoop responder: one outstanding probe, MOESI transition on hit, registered response.
module moesi_snoop_responder
  import moesi_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned IDX_WID   = 4,
  parameter int unsigned TAG_WID   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         snp_valid,
  output logic                         snp_ready,
  input  logic                         snp_write,
  input  logic [TAG_WID+IDX_WID-1:0]   snp_addr,
  input  logic                         fill_valid,
  input  logic [TAG_WID+IDX_WID-1:0]   fill_addr,
  input  logic [MOESI_WID-1:0]         fill_state,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_hit,
  output logic                         rsp_shared,
  output logic                         rsp_supply,
  output logic                         rsp_dirty,
  output logic [MOESI_WID-1:0]         rsp_prev_state,
  output logic                         probe_read_hit,
  output logic                         probe_write_hit
);

  localparam int unsigned ADDR_WID = TAG_WID + IDX_WID;

  fsm_e                 state_q, state_d;
  logic                 snp_write_q, snp_write_d;
  logic [ADDR_WID-1:0]  snp_addr_q, snp_addr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic                 rsp_shared_q, rsp_shared_d;
  logic                 rsp_supply_q, rsp_supply_d;
  logic                 rsp_dirty_q, rsp_dirty_d;
  logic [MOESI_WID-1:0] rsp_prev_q, rsp_prev_d;

  logic                 snp_ready_c;
  logic                 upd_en_c;
  logic                 prh_c, pwh_c;
  logic [TAG_WID-1:0]   rd_tag;
  logic [MOESI_WID-1:0] rd_state;
  logic                 hit_c;
  logic                 illegal_c;
  probe_res_t           nxt_c;

  moesi_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_WID   (IDX_WID),
    .TAG_WID   (TAG_WID)
  ) u_lines (
    .clk          (clk),
    .reset        (reset),
    .fill_en_i    (fill_valid),
    .fill_idx_i   (fill_addr[IDX_WID-1:0]),
    .fill_tag_i   (fill_addr[ADDR_WID-1:IDX_WID]),
    .fill_state_i (fill_state),
    .upd_en_i     (upd_en_c),
    .upd_idx_i    (snp_addr_q[IDX_WID-1:0]),
    .upd_state_i  (nxt_c.state),
    .rd_idx_i     (snp_addr_q[IDX_WID-1:0]),
    .rd_tag_o     (rd_tag),
    .rd_state_o   (rd_state)
  );

  assign hit_c     = (rd_tag == snp_addr_q[ADDR_WID-1:IDX_WID]) && is_valid_state(rd_state);
  assign illegal_c = (rd_state != INVALID) && !is_valid_state(rd_state);
  assign nxt_c     = probe_next_state(rd_state, snp_write_q);

  // Next-state and response capture; the array is read during LOOKUP so late fills are seen.
  always_comb begin
    state_d      = state_q;
    snp_write_d  = snp_write_q;
    snp_addr_d   = snp_addr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_hit_d    = rsp_hit_q;
    rsp_shared_d = rsp_shared_q;
    rsp_supply_d = rsp_supply_q;
    rsp_dirty_d  = rsp_dirty_q;
    rsp_prev_d   = rsp_prev_q;
    snp_ready_c  = 1'b0;
    upd_en_c     = 1'b0;
    prh_c        = 1'b0;
    pwh_c        = 1'b0;
    unique case (state_q)
      IDLE: begin
        snp_ready_c = 1'b1;
        if (snp_valid) begin
          snp_write_d = snp_write;
          snp_addr_d  = snp_addr;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        rsp_valid_d  = 1'b1;
        rsp_hit_d    = hit_c;
        rsp_shared_d = hit_c && !snp_write_q;
        rsp_supply_d = hit_c && nxt_c.supply;
        rsp_dirty_d  = hit_c && nxt_c.dirty;
        rsp_prev_d   = rd_state;
        upd_en_c     = (hit_c || illegal_c) && !reset;
        prh_c        = hit_c && !snp_write_q && !reset;
        pwh_c        = hit_c && snp_write_q && !reset;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      snp_write_q  <= 1'b0;
      snp_addr_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_shared_q <= 1'b0;
      rsp_supply_q <= 1'b0;
      rsp_dirty_q  <= 1'b0;
      rsp_prev_q   <= INVALID;
    end else begin
      state_q      <= state_d;
      snp_write_q  <= snp_write_d;
      snp_addr_q   <= snp_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_shared_q <= rsp_shared_d;
      rsp_supply_q <= rsp_supply_d;
      rsp_dirty_q  <= rsp_dirty_d;
      rsp_prev_q   <= rsp_prev_d;
    end
  end

  assign snp_ready       = snp_ready_c && !reset;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_hit         = rsp_hit_q;
  assign rsp_shared      = rsp_shared_q;
  assign rsp_supply      = rsp_supply_q;
  assign rsp_dirty       = rsp_dirty_q;
  assign rsp_prev_state  = rsp_prev_q;
  assign probe_read_hit  = prh_c;
  assign probe_write_hit = pwh_c;

endmodule

// File: tb/tb_moesi_snoop_responder.sv
// Directed bench for moesi_snoop_responder with a queue of expected probe responses.
module tb_moesi_snoop_responder;
  import moesi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        snp_valid, snp_ready, snp_write;
  logic [11:0] snp_addr;
  logic        fill_valid;
  logic [11:0] fill_addr;
  logic [2:0]  fill_state;
  logic        rsp_valid, rsp_ready, rsp_hit, rsp_shared, rsp_supply, rsp_dirty;
  logic [2:0]  rsp_prev_state;
  logic        probe_read_hit, probe_write_hit;

  typedef struct packed {
    logic       hit;
    logic       shared;
    logic       supply;
    logic       dirty;
    logic [2:0] prev;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  moesi_snoop_responder dut (
    .clk             (clk),
    .reset           (reset),
    .snp_valid       (snp_valid),
    .snp_ready       (snp_ready),
    .snp_write       (snp_write),
    .snp_addr        (snp_addr),
    .fill_valid      (fill_valid),
    .fill_addr       (fill_addr),
    .fill_state      (fill_state),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_hit         (rsp_hit),
    .rsp_shared      (rsp_shared),
    .rsp_supply      (rsp_supply),
    .rsp_dirty       (rsp_dirty),
    .rsp_prev_state  (rsp_prev_state),
    .probe_read_hit  (probe_read_hit),
    .probe_write_hit (probe_write_hit)
  );

  function automatic exp_t mk(input logic h, input logic sh, input logic su,
                              input logic d, input logic [2:0] p);
    exp_t e;
    e.hit = h; e.shared = sh; e.supply = su; e.dirty = d; e.prev = p;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [11:0] a, input logic [2:0] s);
    fill_valid = 1'b1; fill_addr = a; fill_state = s;
    @(posedge clk); #1;
    fill_valid = 1'b0;
  endtask

  // Offer a probe until accepted (bounded); returns in the LOOKUP cycle.
  task automatic start_probe(input logic w, input logic [11:0] a, input exp_t e);
    logic acc;
    acc = 1'b0;
    sb.push_back(e);
    snp_valid = 1'b1; snp_write = w; snp_addr = a;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk); acc = snp_ready;
      @(posedge clk); #1;
    end
    snp_valid = 1'b0;
    chk("accept", 8'(acc), 8'd1);
  endtask

  task automatic check_lookup(input logic prh, input logic pwh);
    @(negedge clk);
    chk("lookup_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("lookup_snp_ready", 8'(snp_ready), 8'd0);
    chk("probe_read_hit", 8'(probe_read_hit), 8'(prh));
    chk("probe_write_hit", 8'(probe_write_hit), 8'(pwh));
    @(posedge clk); #1;
  endtask

  task automatic check_resp();
    exp_t e;
    @(negedge clk);
    chk("rsp_valid", 8'(rsp_valid), 8'd1);
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("rsp_hit", 8'(rsp_hit), 8'(e.hit));
      chk("rsp_shared", 8'(rsp_shared), 8'(e.shared));
      chk("rsp_supply", 8'(rsp_supply), 8'(e.supply));
      chk("rsp_dirty", 8'(rsp_dirty), 8'(e.dirty));
      chk("rsp_prev_state", 8'(rsp_prev_state), 8'(e.prev));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; snp_valid = 1'b0; snp_write = 1'b0; snp_addr = '0;
    fill_valid = 1'b0; fill_addr = '0; fill_state = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_snp_ready", 8'(snp_ready), 8'd0);
    chk("reset_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("reset_rsp_hit", 8'(rsp_hit), 8'd0);
    chk("reset_prev", 8'(rsp_prev_state), 8'd0);
    chk("reset_prh", 8'(probe_read_hit), 8'd0);
    chk("reset_pwh", 8'(probe_write_hit), 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_snp_ready", 8'(snp_ready), 8'd1);
    @(posedge clk); #1;

    // Miss after reset
    start_probe(1'b0, 12'h013, mk(1'b0, 1'b0, 1'b0, 1'b0, INVALID));
    check_lookup(1'b0, 1'b0);
    check_resp();

    // Modified line read twice: M->O, then O stays O
    fill(12'h025, MODIFIED);
    start_probe(1'b0, 12'h025, mk(1'b1, 1'b1, 1'b1, 1'b1, MODIFIED));
    check_lookup(1'b1, 1'b0);
    check_resp();
    start_probe(1'b0, 12'h025, mk(1'b1, 1'b1, 1'b1, 1'b1, OWNED));
    check_lookup(1'b1, 1'b0);
    check_resp();

    // Exclusive line invalidated by probe write
    fill(12'h037, EXCLUSIVE);
    start_probe(1'b1, 12'h037, mk(1'b1, 1'b0, 1'b0, 1'b0, EXCLUSIVE));
    check_lookup(1'b0, 1'b1);
    check_resp();
    start_probe(1'b0, 12'h037, mk(1'b0, 1'b0, 1'b0, 1'b0, INVALID));
    check_lookup(1'b0, 1'b0);
    check_resp();

    // Response back-pressure with a second probe waiting
    rsp_ready = 1'b0;
    start_probe(1'b0, 12'h025, mk(1'b1, 1'b1, 1'b1, 1'b1, OWNED));
    check_lookup(1'b1, 1'b0);
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, INVALID));
    snp_valid = 1'b1; snp_write = 1'b0; snp_addr = 12'h013;
    repeat (4) begin
      @(negedge clk);
      chk("hold_rsp_valid", 8'(rsp_valid), 8'd1);
      chk("hold_prev", 8'(rsp_prev_state), 8'(OWNED));
      chk("hold_supply", 8'(rsp_supply), 8'd1);
      chk("hold_dirty", 8'(rsp_dirty), 8'd1);
      chk("hold_snp_ready", 8'(snp_ready), 8'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    check_resp();
    @(negedge clk);
    chk("ready_after_handshake", 8'(snp_ready), 8'd1);
    @(posedge clk); #1;
    snp_valid = 1'b0;
    check_lookup(1'b0, 1'b0);
    check_resp();

    // Fill collides with the snoop update of a probe write
    fill(12'h048, MODIFIED);
    start_probe(1'b1, 12'h048, mk(1'b1, 1'b0, 1'b1, 1'b1, MODIFIED));
    fill_valid = 1'b1; fill_addr = 12'h048; fill_state = SHARED;
    check_lookup(1'b0, 1'b1);
    fill_valid = 1'b0;
    check_resp();
    start_probe(1'b0, 12'h048, mk(1'b1, 1'b1, 1'b0, 1'b0, SHARED));
    check_lookup(1'b1, 1'b0);
    check_resp();

    // Tag mismatch reports the stored code without a state change
    fill(12'h058, SHARED);
    start_probe(1'b0, 12'h048, mk(1'b0, 1'b0, 1'b0, 1'b0, SHARED));
    check_lookup(1'b0, 1'b0);
    check_resp();
    start_probe(1'b0, 12'h058, mk(1'b1, 1'b1, 1'b0, 1'b0, SHARED));
    check_lookup(1'b1, 1'b0);
    check_resp();

    // Reset while a response is pending
    fill(12'h06A, OWNED);
    rsp_ready = 1'b0;
    start_probe(1'b0, 12'h06A, mk(1'b1, 1'b1, 1'b1, 1'b1, OWNED));
    check_lookup(1'b1, 1'b0);
    @(negedge clk);
    chk("pre_reset_rsp_valid", 8'(rsp_valid), 8'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_rsp_hit", 8'(rsp_hit), 8'd0);
    chk("rst_prev", 8'(rsp_prev_state), 8'd0);
    chk("rst_snp_ready", 8'(snp_ready), 8'd0);
    sb.delete();
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_reset_snp_ready", 8'(snp_ready), 8'd1);
    @(posedge clk); #1;
    start_probe(1'b0, 12'h06A, mk(1'b0, 1'b0, 1'b0, 1'b0, INVALID));
    check_lookup(1'b0, 1'b0);
    check_resp();
    start_probe(1'b0, 12'h025, mk(1'b0, 1'b0, 1'b0, 1'b0, INVALID));
    check_lookup(1'b0, 1'b0);
    check_resp();
    start_probe(1'b0, 12'h058, mk(1'b0, 1'b0, 1'b0, 1'b0, INVALID));
    check_lookup(1'b0, 1'b0);
    check_resp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
